// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator: walks two WIDTH-bit operands MSB first through one
// less/greater/equal cascade cell. Define SERIAL_CMP_EARLY_EXIT_EN to stop at the first differing bit.
module serial_compare_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic [CW-1:0]    cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    bit_cnt;
  logic             prev_less, prev_greater, prev_equal;
  logic             curr_less, curr_greater, curr_equal;
  logic             last_bit;

  // One-bit compare cell: a decision made at a more significant bit is never overturned.
  always_comb begin
    curr_less    = prev_less    | (prev_equal & ~sh_a[WIDTH-1] &  sh_b[WIDTH-1]);
    curr_greater = prev_greater | (prev_equal &  sh_a[WIDTH-1] & ~sh_b[WIDTH-1]);
    curr_equal   = prev_equal   & ~(sh_a[WIDTH-1] ^ sh_b[WIDTH-1]);
  end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign last_bit = (bit_cnt == CW'(WIDTH - 1)) || curr_less || curr_greater;
`else
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Decoded from the state register only, so no input reaches these outputs combinationally.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a         <= '0;
      sh_b         <= '0;
      bit_cnt      <= '0;
      prev_less    <= 1'b0;
      prev_greater <= 1'b0;
      prev_equal   <= 1'b0;
      a_lt_b       <= 1'b0;
      a_gt_b       <= 1'b0;
      a_eq_b       <= 1'b0;
      cycles       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a         <= in_a;
            sh_b         <= in_b;
            bit_cnt      <= '0;
            prev_less    <= 1'b0;
            prev_greater <= 1'b0;
            prev_equal   <= 1'b1;
          end
        end
        RUN: begin
          sh_a         <= sh_a << 1;
          sh_b         <= sh_b << 1;
          bit_cnt      <= bit_cnt + CW'(1);
          prev_less    <= curr_less;
          prev_greater <= curr_greater;
          prev_equal   <= curr_equal;
          // Results only move on the edge that enters DONE; a new start leaves them alone.
          if (last_bit) begin
            a_lt_b <= curr_less;
            a_gt_b <= curr_greater;
            a_eq_b <= curr_equal;
            cycles <= bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
